display_arbiter: RTL

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter_if.sv | 30 +++
 rtl/display_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - requester, downstream and status signals of the display arbiter
interface display_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_is_neg;
  logic [NUM_REQ-1:0]            i_req_error;
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [DATA_WIDTH-1:0]         o_data;
  logic                          o_data_is_neg;
  logic                          o_error;
  logic                          o_valid;
  logic                          i_ready;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_busy;

  // Environment side: requesters and the display driver
  modport master (
    output i_req_data, i_req_is_neg, i_req_error, i_req_valid, i_ready,
    input  o_req_ready, o_data, o_data_is_neg, o_error, o_valid, o_grant, o_busy
  );

  // Arbiter side
  modport slave (
    input  i_req_data, i_req_is_neg, i_req_error, i_req_valid, i_ready,
    output o_req_ready, o_data, o_data_is_neg, o_error, o_valid, o_grant, o_busy
  );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin arbiter feeding one display driver with a post-transfer dwell
module display_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  display_arbiter_if.slave bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = (DWELL_CYCLES > 0) ? CW'(DWELL_CYCLES - 1) : '0;
  localparam logic [GW-1:0] LAST_INIT  = GW'(NUM_REQ - 1);

  if (DATA_WIDTH < 4 || (DATA_WIDTH % 4) != 0) begin : g_bad_width
    $fatal(1, "display_arbiter: DATA_WIDTH must be a multiple of 4 and >= 4");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "display_arbiter: NUM_REQ must be >= 2");
  end
  if (DWELL_CYCLES < 0) begin : g_bad_dwell
    $fatal(1, "display_arbiter: DWELL_CYCLES must be >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         dwell_cnt;
  logic [CW-1:0]         dwell_cnt_next;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         sel;
  logic                  any_valid;
  logic                  accept;
  logic [NUM_REQ-1:0]    ready_vec;
  logic [DATA_WIDTH-1:0] held_data;
  logic                  held_neg;
  logic                  held_err;

  // Round-robin pick: the requester closest after last_grant wins, so the
  // loop walks backwards and the nearest valid one overwrites the others.
  always_comb begin
    any_valid = |bus.i_req_valid;
    sel       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (bus.i_req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        sel = GW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // State and dwell counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_cnt_next;
    end
  end

  // Next state, dwell count and requester acknowledge
  always_comb begin
    state_next     = state;
    dwell_cnt_next = dwell_cnt;
    accept         = 1'b0;
    ready_vec      = '0;
    case (state)
      S_IDLE: begin
        if (any_valid && !rst) begin
          ready_vec  = NUM_REQ'(1) << sel;
          accept     = 1'b1;
          state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        if (bus.i_ready) begin
          if (DWELL_CYCLES == 0) begin
            state_next = S_IDLE;
          end else begin
            dwell_cnt_next = DWELL_LOAD;
            state_next     = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (dwell_cnt == '0) begin
          state_next = S_IDLE;
        end else begin
          dwell_cnt_next = dwell_cnt - 1'b1;
        end
      end
      default: begin
        state_next     = S_IDLE;
        dwell_cnt_next = '0;
      end
    endcase
  end

  // Capture the winner's value and remember it for the next round-robin pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_data  <= '0;
      held_neg   <= 1'b0;
      held_err   <= 1'b0;
      last_grant <= LAST_INIT;
    end else if (accept) begin
      held_data  <= bus.i_req_data[sel*DATA_WIDTH +: DATA_WIDTH];
      held_neg   <= bus.i_req_is_neg[sel];
      held_err   <= bus.i_req_error[sel];
      last_grant <= sel;
    end
  end

  // Outputs decode straight from state so reset removes them at once
  always_comb begin
    bus.o_req_ready   = ready_vec;
    bus.o_valid       = (state == S_OFFER);
    bus.o_busy        = (state != S_IDLE);
    bus.o_grant       = (state == S_OFFER || state == S_DWELL) ? (NUM_REQ'(1) << last_grant) : '0;
    bus.o_data        = held_data;
    bus.o_data_is_neg = held_neg;
    bus.o_error       = held_err;
  end

endmodule
